// File: rtl/enemy_run_anim_sequencer.sv
// Running-enemy walk-cycle sequencer: vsync-driven frame stepping plus a 2-stage raster-to-palette pipeline.
// Optional build macro MIRROR_EN adds a 'mirror' input that flips the sprite horizontally.
module enemy_run_anim_sequencer #(
  parameter int NUM_FRAMES      = 5,
  parameter int SPR_W           = 24,
  parameter int SPR_H           = 32,
  parameter int TICKS_PER_FRAME = 6,
  parameter int ADDR_W          = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              run_en,
  input  logic [9:0]        enemy_x,
  input  logic [9:0]        enemy_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
`ifdef MIRROR_EN
  input  logic              mirror,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic [2:0]        pix_index,
  output logic              pix_valid,
  output logic [2:0]        frame_num
);

  localparam int TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_n;
  logic [2:0]      frame_q, frame_n;
  logic [TW-1:0]   tick_q, tick_n;
  logic            fclk_q;
  logic            tick;
  logic            adv;
  logic            count;

  // Frames are laid out back-to-back in ROM, each stored row-major.
  function automatic logic [ADDR_W-1:0] sprite_addr(input logic [2:0] frame,
                                                    input logic [9:0] row,
                                                    input logic [9:0] col);
    return ADDR_W'(32'(frame) * 32'(SPR_W * SPR_H) + 32'(row) * 32'(SPR_W) + 32'(col));
  endfunction

  assign tick = frame_clk & ~fclk_q;
  assign adv  = tick && (tick_q == TW'(TICKS_PER_FRAME - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      tick_q  <= '0;
      fclk_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      frame_q <= frame_n;
      tick_q  <= tick_n;
      fclk_q  <= frame_clk;
    end
  end

  always_comb begin
    state_n = state_q;
    frame_n = frame_q;
    tick_n  = tick_q;
    count   = 1'b0;
    unique case (state_q)
      IDLE: begin
        frame_n = '0;
        tick_n  = '0;
        if (run_en) state_n = RUN;
      end
      RUN: begin
        count = 1'b1;
        if (!run_en) state_n = DRAIN;
      end
      DRAIN: begin
        if (run_en) begin
          count   = 1'b1;
          state_n = RUN;
        end else if (adv) begin
          // Stop on the frame boundary and park on frame 0.
          frame_n = '0;
          tick_n  = '0;
          state_n = IDLE;
        end else begin
          count = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (count && tick) begin
      if (adv) begin
        tick_n  = '0;
        frame_n = (frame_q == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q + 3'd1;
      end else begin
        tick_n = tick_q + TW'(1);
      end
    end
  end

  assign frame_num = frame_q;

  // Stage p0: raster offset relative to sprite origin; left/above wraps large.
  logic [9:0] dx_p0, dy_p0, dx_eff_p0;
  logic       inbox_p0;

  assign dx_p0    = DrawX - enemy_x;
  assign dy_p0    = DrawY - enemy_y;
  assign inbox_p0 = (dx_p0 < 10'(SPR_W)) && (dy_p0 < 10'(SPR_H));

`ifdef MIRROR_EN
  assign dx_eff_p0 = mirror ? (10'(SPR_W - 1) - dx_p0) : dx_p0;
`else
  assign dx_eff_p0 = dx_p0;
`endif

  // Stage p1: registered ROM address; p2: palette index with transparency key 0.
  logic [ADDR_W-1:0] rom_addr_p1;
  logic              vld_p1;
  logic [2:0]        pix_index_p2;
  logic              vld_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr_p1  <= '0;
      vld_p1       <= 1'b0;
      pix_index_p2 <= '0;
      vld_p2       <= 1'b0;
    end else begin
      if (inbox_p0) rom_addr_p1 <= sprite_addr(frame_q, dy_p0, dx_eff_p0);
      vld_p1       <= inbox_p0;
      pix_index_p2 <= rom_data;
      vld_p2       <= vld_p1 && (rom_data != 3'd0);
    end
  end

  assign rom_addr  = rom_addr_p1;
  assign pix_index = pix_index_p2;
  assign pix_valid = vld_p2;

endmodule

// File: tb/tb_enemy_run_anim_sequencer.sv
// Self-checking bench for enemy_run_anim_sequencer: directed scenarios plus randomized traffic vs a tick-count model.
module tb_enemy_run_anim_sequencer;
  localparam int NF  = 5;
  localparam int SW  = 24;
  localparam int SH  = 32;
  localparam int TPF = 6;
  localparam int AW  = 12;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          frame_clk = 1'b0;
  logic          run_en = 1'b0;
  logic [9:0]    enemy_x = '0, enemy_y = '0, DrawX = '0, DrawY = '0;
`ifdef MIRROR_EN
  logic          mirror = 1'b0;
`endif
  logic [AW-1:0] rom_addr;
  logic [2:0]    rom_data;
  logic [2:0]    pix_index;
  logic          pix_valid;
  logic [2:0]    frame_num;

  int rom_force = -1;
  int checks = 0;
  int failures = 0;

  // Model: total ticks since the run started; frame follows by division.
  int m_mode = M_IDLE, m_total = 0, m_addr = 0, m_idx = 0;
  bit m_vld = 0, m_ib1 = 0, m_fq = 0;

  enemy_run_anim_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .run_en(run_en),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .DrawX(DrawX), .DrawY(DrawY),
`ifdef MIRROR_EN
    .mirror(mirror),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_index(pix_index),
    .pix_valid(pix_valid), .frame_num(frame_num)
  );

  always #5 Clk = ~Clk;

  // Asynchronous-read ROM image (registered address makes the total latency 2).
  always_comb begin
    if (rom_force >= 0) rom_data = 3'(rom_force);
    else rom_data = 3'((int'(rom_addr) * 5 + (int'(rom_addr) >> 4)) & 7);
  end

  function automatic int rom_val(int a);
    if (rom_force >= 0) return rom_force;
    return (a * 5 + (a >> 4)) & 7;
  endfunction

  function automatic int m_frame();
    return (m_total / TPF) % NF;
  endfunction

  task automatic step();
    int dx, dy, fr, col;
    bit ib, tk, mir;
    fr = m_frame();
    dx = (int'(DrawX) - int'(enemy_x) + 1024) % 1024;
    dy = (int'(DrawY) - int'(enemy_y) + 1024) % 1024;
    ib = (dx < SW) && (dy < SH);
    mir = 1'b0;
`ifdef MIRROR_EN
    mir = mirror;
`endif
    col = mir ? (SW - 1 - dx) : dx;
    if (Reset) begin
      m_mode = M_IDLE; m_total = 0; m_fq = 0;
      m_addr = 0; m_ib1 = 0; m_idx = 0; m_vld = 0;
    end else begin
      m_idx = rom_val(m_addr);
      m_vld = m_ib1 && (m_idx != 0);
      if (ib) m_addr = (fr * SW * SH + dy * SW + col) % (1 << AW);
      m_ib1 = ib;
      tk = frame_clk && !m_fq;
      m_fq = frame_clk;
      if (m_mode == M_IDLE) begin
        m_total = 0;
        if (run_en) m_mode = M_RUN;
      end else begin
        if (tk) m_total++;
        if (m_mode == M_RUN) begin
          if (!run_en) m_mode = M_DRAIN;
        end else if (run_en) begin
          m_mode = M_RUN;
        end else if (tk && (m_total % TPF == 0)) begin
          m_mode = M_IDLE;
          m_total = 0;
        end
      end
    end
    @(negedge Clk);
  endtask

  task automatic do_tick();
    frame_clk = 1'b1; step();
    frame_clk = 1'b0; step();
  endtask

  task automatic do_reset();
    Reset = 1'b1; step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; run_en = 1'b1; step(); step();
    checks++; if (frame_num !== 3'd0) begin failures++; $display("FAIL reset_frame got=%0d want=0", frame_num); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", pix_valid); end
    checks++; if (pix_index !== 3'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", pix_index); end
    Reset = 1'b0;
    enemy_x = 10'd100; enemy_y = 10'd200; DrawX = 10'd105; DrawY = 10'd202; rom_force = 3;
    step();
    repeat (3) do_tick();
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%0b want=1", pix_valid); end
    Reset = 1'b1; step(); step();
    checks++; if (frame_num !== 3'd0) begin failures++; $display("FAIL midrun_reset_frame got=%0d want=0", frame_num); end
    checks++; if (rom_addr !== '0) begin failures++; $display("FAIL midrun_reset_addr got=%0d want=0", rom_addr); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL midrun_reset_valid got=%0b want=0", pix_valid); end
    checks++; if (pix_index !== 3'd0) begin failures++; $display("FAIL midrun_reset_index got=%0d want=0", pix_index); end
    // With run_en low after reset the sequencer must sit idle through a full frame of ticks.
    Reset = 1'b0; run_en = 1'b0; step();
    repeat (TPF) do_tick();
    checks++; if (frame_num !== 3'd0) begin failures++; $display("FAIL reset_idle_frame got=%0d want=0", frame_num); end
  endtask

  task automatic test_cycle();
    int exp;
    do_reset();
    run_en = 1'b1; step();
    for (int k = 0; k < 30; k++) begin
      do_tick();
      exp = ((k + 1) / TPF) % NF;
      checks++;
      if (frame_num !== 3'(exp)) begin
        failures++; $display("FAIL cycle_frame tick=%0d got=%0d want=%0d", k + 1, frame_num, exp);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    run_en = 1'b1; step();
    repeat (15) do_tick();
    checks++; if (frame_num !== 3'd2) begin failures++; $display("FAIL drain_start got=%0d want=2", frame_num); end
    run_en = 1'b0; step();
    for (int k = 0; k < 6; k++) begin
      do_tick();
      checks++;
      if (frame_num !== ((k < 2) ? 3'd2 : 3'd0)) begin
        failures++; $display("FAIL drain_frame tick=%0d got=%0d want=%0d", k + 1, frame_num, (k < 2) ? 2 : 0);
      end
    end
    // Restart from idle: counters must begin from zero.
    run_en = 1'b1; step();
    repeat (TPF) do_tick();
    checks++; if (frame_num !== 3'd1) begin failures++; $display("FAIL drain_restart got=%0d want=1", frame_num); end
  endtask

  task automatic test_address();
    do_reset();
    run_en = 1'b1; step();
    repeat (TPF) do_tick();
    enemy_x = 10'd100; enemy_y = 10'd200; DrawX = 10'd105; DrawY = 10'd202; rom_force = 3;
    step();
    checks++; if (rom_addr !== 12'd821) begin failures++; $display("FAIL addr_basic got=%0d want=821", rom_addr); end
    step();
    checks++; if (pix_index !== 3'd3) begin failures++; $display("FAIL addr_index got=%0d want=3", pix_index); end
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL addr_valid got=%0b want=1", pix_valid); end
`ifdef MIRROR_EN
    mirror = 1'b1; step();
    checks++; if (rom_addr !== 12'd834) begin failures++; $display("FAIL addr_mirror got=%0d want=834", rom_addr); end
    mirror = 1'b0; step();
    checks++; if (rom_addr !== 12'd821) begin failures++; $display("FAIL addr_unmirror got=%0d want=821", rom_addr); end
`endif
  endtask

  task automatic test_edges();
    int tx [7] = '{99, 124, 123, 105, 105, 105, 100};
    int ty [7] = '{202, 202, 202, 231, 232, 202, 200};
    int td [7] = '{3, 3, 3, 3, 3, 0, 5};
    bit tv [7] = '{0, 0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      DrawX = 10'(tx[i]); DrawY = 10'(ty[i]); rom_force = td[i];
      step(); step();
      checks++;
      if (pix_valid !== tv[i]) begin
        failures++; $display("FAIL edge_valid x=%0d y=%0d data=%0d got=%0b want=%0b", tx[i], ty[i], td[i], pix_valid, tv[i]);
      end
    end
    rom_force = -1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run_en = ~run_en;
      frame_clk = ($urandom_range(0, 3) == 0);
      Reset = ($urandom_range(0, 299) == 0);
      if (i % 200 == 0) begin
        enemy_x = 10'($urandom_range(0, 1023));
        enemy_y = 10'($urandom_range(0, 1023));
      end
      DrawX = enemy_x + 10'($urandom_range(0, 40)) - 10'd8;
      DrawY = enemy_y + 10'($urandom_range(0, 48)) - 10'd8;
`ifdef MIRROR_EN
      mirror = 1'($urandom_range(0, 1));
`endif
      step();
      checks++;
      if (frame_num !== 3'(m_frame())) begin failures++; $display("FAIL rand_frame cyc=%0d got=%0d want=%0d", i, frame_num, m_frame()); end
      checks++;
      if (rom_addr !== AW'(m_addr)) begin failures++; $display("FAIL rand_addr cyc=%0d got=%0d want=%0d", i, rom_addr, m_addr); end
      checks++;
      if (pix_index !== 3'(m_idx)) begin failures++; $display("FAIL rand_index cyc=%0d got=%0d want=%0d", i, pix_index, m_idx); end
      checks++;
      if (pix_valid !== m_vld) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", i, pix_valid, m_vld); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clk);
    test_reset();
    test_cycle();
    test_drain();
    test_address();
    test_edges();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
